// File: rtl/tinyalu_defs_pkg.sv
// Shared TinyALU definitions: opcode encoding and opcode-class helpers.
package tinyalu_defs_pkg;

  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100,
    sub_op = 3'b101,
    rsv_op = 3'b110,
    rst_op = 3'b111
  } operation_t;

  localparam int OP_W = 3;

  // Ops that complete one cycle after acceptance and must wait for an empty multiplier.
  function automatic logic is_single_op(operation_t op);
    return (op == add_op) || (op == and_op) || (op == xor_op) || (op == sub_op);
  endfunction

  function automatic logic is_mul_op(operation_t op);
    return op == mul_op;
  endfunction

  function automatic logic is_flush_op(operation_t op);
    return op == rst_op;
  endfunction

endpackage

// File: rtl/tinyalu_param_if.sv
// Request/response bundle between the TinyALU BFM (master) and the core (slave).
interface tinyalu_param_if
  import tinyalu_defs_pkg::*;
#(
  parameter int DATA_W = 8
) ();

  logic [DATA_W-1:0]   A;
  logic [DATA_W-1:0]   B;
  operation_t          op;
  logic                start;
  logic                ready;
  logic                done;
  logic [2*DATA_W-1:0] result;

  modport master (output A, output B, output op, output start,
                  input  ready, input done, input result);

  modport slave  (input  A, input B, input op, input start,
                  output ready, output done, output result);

endinterface

// File: rtl/tinyalu_mul_pipe.sv
// Multiplier with valid shift pipeline; the top-level result register is the final stage,
// so MUL_STAGES-1 internal stages give MUL_STAGES cycles from acceptance to done.
module tinyalu_mul_pipe
  import tinyalu_defs_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int MUL_STAGES = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid_i,
  input  logic                flush_i,
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  output logic                busy_o,
  output logic                out_valid_o,
  output logic [2*DATA_W-1:0] product_o
);

  localparam int PW    = 2 * DATA_W;
  localparam int DEPTH = MUL_STAGES - 1;

  logic [PW-1:0] prod_now;
  assign prod_now = PW'(a_i) * PW'(b_i);

  generate
    if (DEPTH == 0) begin : g_comb
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, reset_n, flush_i};
      assign busy_o      = 1'b0;
      assign out_valid_o = in_valid_i;
      assign product_o   = prod_now;
    end else begin : g_pipe
      logic [DEPTH-1:0] vld_q;
      logic [PW-1:0]    prod_q [DEPTH];

      always_ff @(posedge clk) begin
        if (!reset_n || flush_i) begin
          vld_q <= '0;
        end else begin
          vld_q <= DEPTH'({vld_q, in_valid_i});
        end
      end

      // Product data is not reset; only the valid bits decide what retires.
      always_ff @(posedge clk) begin
        prod_q[0] <= prod_now;
        for (int i = 1; i < DEPTH; i++) begin
          prod_q[i] <= prod_q[i-1];
        end
      end

      assign busy_o      = |vld_q;
      assign out_valid_o = vld_q[DEPTH-1];
      assign product_o   = prod_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/tinyalu_param.sv
// Parametrised TinyALU: single-cycle add/and/xor/sub, pipelined multiply, in-order completion.
module tinyalu_param
  import tinyalu_defs_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int MUL_STAGES = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  tinyalu_param_if.slave bus
);

  localparam int RW = 2 * DATA_W;

  logic          mul_busy;
  logic          mul_out_valid;
  logic [RW-1:0] mul_product;
  logic          accept;
  logic          sc_acc;
  logic          mul_acc;
  logic          flush_acc;
  logic [RW-1:0] result_d, result_q;
  logic          done_d, done_q;

  // Sub is the true difference of the unsigned operands, carried as a DATA_W+1 bit signed value.
  function automatic logic [RW-1:0] alu_single(operation_t op,
                                               logic [DATA_W-1:0] a,
                                               logic [DATA_W-1:0] b);
    logic signed [DATA_W:0] diff;
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    case (op)
      add_op:  return RW'(a) + RW'(b);
      and_op:  return RW'(a & b);
      xor_op:  return RW'(a ^ b);
      sub_op:  return {{(RW-DATA_W-1){diff[DATA_W]}}, diff};
      default: return '0;
    endcase
  endfunction

  assign bus.ready = reset_n && !(bus.start && is_single_op(bus.op) && mul_busy);
  assign accept    = bus.start && bus.ready;
  assign sc_acc    = accept && is_single_op(bus.op);
  assign mul_acc   = accept && is_mul_op(bus.op);
  assign flush_acc = accept && is_flush_op(bus.op);

  tinyalu_mul_pipe #(
    .DATA_W     (DATA_W),
    .MUL_STAGES (MUL_STAGES)
  ) u_mul_pipe (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid_i  (mul_acc),
    .flush_i     (flush_acc),
    .a_i         (bus.A),
    .b_i         (bus.B),
    .busy_o      (mul_busy),
    .out_valid_o (mul_out_valid),
    .product_o   (mul_product)
  );

  // Flush wins over a multiply retiring in the same cycle.
  always_comb begin
    result_d = result_q;
    done_d   = 1'b0;
    if (flush_acc) begin
      result_d = '0;
    end else if (sc_acc) begin
      done_d   = 1'b1;
      result_d = alu_single(bus.op, bus.A, bus.B);
    end else if (mul_out_valid) begin
      done_d   = 1'b1;
      result_d = mul_product;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;

  a_one_completion : assert property (@(posedge clk) disable iff (!reset_n)
                                      !(mul_out_valid && sc_acc));

endmodule
